// File: rtl/comb_decimator.sv
// comb_decimator: decimating comb section of a CIC decimator.
// Keeps every R-th strobed input sample, runs the decimated stream through
// STAGES comb stages y = x - x[n-M], and registers the truncated result
// into a held output with a single-cycle strobe.
// Latency from the edge accepting the kept sample to the output strobe is
// STAGES+1 cycles: decimation register, STAGES comb registers, output register.
module comb_decimator #(
  parameter int DATA_WIDTH_INP = 32,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int R              = 8,
  parameter int M              = 1,
  parameter int STAGES         = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic signed [DATA_WIDTH_INP-1:0]  inp_samp_data,
  input  logic                              inp_samp_str,
  output logic signed [DATA_WIDTH_OUT-1:0]  out_samp_data,
  output logic                              out_samp_str
);

  localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  // Output is the top DATA_WIDTH_OUT bits of the comb result: plain truncation.
  function automatic logic signed [DATA_WIDTH_OUT-1:0] f_trunc(
    input logic signed [DATA_WIDTH_INP-1:0] v
  );
    return v[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
  endfunction

  logic [CNT_W-1:0]                 r_cnt;
  logic signed [DATA_WIDTH_INP-1:0] r_dec_p0;
  logic                             r_vld_p0;
  logic                             w_keep;

  // Comb chain taps: index 0 is the decimated sample, index k+1 is stage k.
  logic [STAGES:0][DATA_WIDTH_INP-1:0] w_x;
  logic [STAGES:0]                     w_vld;

  logic signed [DATA_WIDTH_OUT-1:0] r_out;
  logic                             r_out_vld;

  assign w_keep = inp_samp_str && (r_cnt == CNT_LAST);

  // ---- stage p0: decimation counter and decimation register ----
  // Count input strobes modulo R and capture the R-th sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_dec_p0 <= '0;
      r_vld_p0 <= 1'b0;
    end else if (clear) begin
      r_cnt    <= '0;
      r_dec_p0 <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_keep;
      if (inp_samp_str) begin
        r_cnt <= w_keep ? '0 : r_cnt + 1'b1;
      end
      if (w_keep) begin
        r_dec_p0 <= inp_samp_data;
      end
    end
  end

  assign w_x[0]   = r_dec_p0;
  assign w_vld[0] = r_vld_p0;

  // ---- stages p1..pSTAGES: comb stages ----
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic signed [DATA_WIDTH_INP-1:0] r_comb_p;
    logic                             r_vld_p;
    logic signed [DATA_WIDTH_INP-1:0] r_dly [M];
    logic signed [DATA_WIDTH_INP-1:0] w_in;

    assign w_in = $signed(w_x[k]);

    // On each input strobe: y = x - x delayed by M strobes, then shift the delay line.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_comb_p <= '0;
        r_vld_p  <= 1'b0;
        for (int j = 0; j < M; j++) r_dly[j] <= '0;
      end else if (clear) begin
        r_comb_p <= '0;
        r_vld_p  <= 1'b0;
        for (int j = 0; j < M; j++) r_dly[j] <= '0;
      end else begin
        r_vld_p <= w_vld[k];
        if (w_vld[k]) begin
          r_comb_p <= w_in - r_dly[M-1];
          r_dly[0] <= w_in;
          for (int j = 1; j < M; j++) r_dly[j] <= r_dly[j-1];
        end
      end
    end

    assign w_x[k+1]   = r_comb_p;
    assign w_vld[k+1] = r_vld_p;
  end

  // ---- output stage: truncate and hold between strobes ----
  // Register the final comb result and its single-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else if (clear) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= w_vld[STAGES];
      if (w_vld[STAGES]) begin
        r_out <= f_trunc($signed(w_x[STAGES]));
      end
    end
  end

  assign out_samp_data = r_out;
  assign out_samp_str  = r_out_vld;

endmodule

// File: tb/tb_comb_decimator.sv
// Bench for comb_decimator: three configurations driven with directed vectors.
// Expected outputs (value and cycle of arrival) are queued when stimulus is
// issued; per-instance monitors pop and compare on every output strobe.
module tb_comb_decimator;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Instance A: R=4 M=1 STAGES=3, 16/16
  logic               clr_a;
  logic signed [15:0] da;
  logic               sa;
  logic signed [15:0] oa;
  logic               osa;
  // Instance B: R=1 M=1 STAGES=1, 8/8
  logic               clr_b;
  logic signed [7:0]  db;
  logic               sb;
  logic signed [7:0]  ob;
  logic               osb;
  // Instance C: R=1 M=2 STAGES=1, 16 in / 8 out
  logic               clr_c;
  logic signed [15:0] dc;
  logic               sc;
  logic signed [7:0]  oc;
  logic               osc;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  int ramp_exp [5] = '{4, -4, 0, 0, 0};
  int diff_exp [5] = '{1, 2, 2, 2, 2};

  comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .R(4), .M(1), .STAGES(3)) u_a (
    .clk(clk), .reset_n(rst_n), .clear(clr_a),
    .inp_samp_data(da), .inp_samp_str(sa),
    .out_samp_data(oa), .out_samp_str(osa)
  );

  comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .R(1), .M(1), .STAGES(1)) u_b (
    .clk(clk), .reset_n(rst_n), .clear(clr_b),
    .inp_samp_data(db), .inp_samp_str(sb),
    .out_samp_data(ob), .out_samp_str(osb)
  );

  comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(8), .R(1), .M(2), .STAGES(1)) u_c (
    .clk(clk), .reset_n(rst_n), .clear(clr_c),
    .inp_samp_data(dc), .inp_samp_str(sc),
    .out_samp_data(oc), .out_samp_str(osc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input int act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d expected=no_strobe", nm, act);
  endtask

  // Monitors: pop one expectation per output strobe
  always @(negedge clk) begin
    if (rst_n === 1'b1 && osa === 1'b1) begin
      if (qa.size() == 0) unexpected("a_unexpected_strobe", int'(oa));
      else begin
        ea = qa.pop_front();
        cmp("a_data", int'(oa), ea.data);
        cmp("a_latency", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && osb === 1'b1) begin
      if (qb.size() == 0) unexpected("b_unexpected_strobe", int'(ob));
      else begin
        eb = qb.pop_front();
        cmp("b_data", int'(ob), eb.data);
        cmp("b_latency", cyc, eb.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && osc === 1'b1) begin
      if (qc.size() == 0) unexpected("c_unexpected_strobe", int'(oc));
      else begin
        ec = qc.pop_front();
        cmp("c_data", int'(oc), ec.data);
        cmp("c_latency", cyc, ec.cyc);
      end
    end
  end

  // Called at a negedge; the following posedge accepts the strobe.
  // Output arrives STAGES+1 edges after that accepting edge.
  task automatic drive_a(input int d, input bit keep, input int exp, input int gap);
    if (keep) qa.push_back('{exp, cyc + 5});
    da = 16'(d);
    sa = 1'b1;
    @(negedge clk);
    sa = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive_b(input int d, input int exp);
    qb.push_back('{exp, cyc + 3});
    db = 8'(d);
    sb = 1'b1;
    @(negedge clk);
    sb = 1'b0;
  endtask

  task automatic drive_c(input int d, input int exp);
    qc.push_back('{exp, cyc + 3});
    dc = 16'(d);
    sc = 1'b1;
    @(negedge clk);
    sc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    da = '0; sa = 1'b0;
    db = '0; sb = 1'b0;
    dc = '0; sc = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst_a_data", int'(oa), 0);
    cmp("rst_a_str", int'(osa), 0);
    cmp("rst_b_data", int'(ob), 0);
    cmp("rst_c_str", int'(osc), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 1..20: decimated 4,8,12,16,20 -> 4,-4,0,0,0; gaps only after strobe 8
    for (int i = 1; i <= 20; i++) begin
      if (i % 4 == 0) drive_a(i, 1'b1, ramp_exp[i/4 - 1], (i > 8 && i % 3 == 0) ? 1 : 0);
      else            drive_a(i, 1'b0, 0, (i > 8 && i % 3 == 0) ? 1 : 0);
    end
    repeat (8) @(negedge clk);

    // Clear mid-frame (with an ignored strobe in the clear cycle), then 4 x 7
    drive_a(11, 1'b0, 0, 0);
    drive_a(12, 1'b0, 0, 0);
    clr_a = 1'b1; da = 16'sd99; sa = 1'b1;
    @(negedge clk);
    clr_a = 1'b0; sa = 1'b0;
    for (int j = 0; j < 4; j++) drive_a(7, j == 3, 7, 0);
    repeat (8) @(negedge clk);
    cmp("a_hold_data", int'(oa), 7);
    cmp("a_hold_str", int'(osa), 0);

    // Kept sample in flight when clear arrives: never output; output zeroed
    for (int j = 0; j < 4; j++) drive_a(50, 1'b0, 0, 0);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    cmp("a_clear_data", int'(oa), 0);
    cmp("a_clear_str", int'(osa), 0);
    repeat (8) @(negedge clk);

    // Fresh frame after clear
    for (int j = 0; j < 4; j++) drive_a(9, j == 3, 9, 0);
    repeat (8) @(negedge clk);
    cmp("pre_async_data", int'(oa), 9);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_data", int'(oa), 0);
    cmp("async_str", int'(osa), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 4; j++) drive_a(5, j == 3, 5, 0);
    repeat (8) @(negedge clk);

    // Wrap-around: 100, -56 (200 in 8 bits) -> 100, 100
    drive_b(100, 100);
    drive_b(-56, 100);
    repeat (5) @(negedge clk);

    // Differential delay M=2 with truncation 16->8: 256*n -> 1,2,2,2,2
    for (int i = 1; i <= 5; i++) drive_c(i * 256, diff_exp[i-1]);
    repeat (5) @(negedge clk);

    cmp("a_queue_empty", qa.size(), 0);
    cmp("b_queue_empty", qb.size(), 0);
    cmp("c_queue_empty", qc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
